// File: rtl/magia_tile_ctrl_mbox.sv
// -----------------------------------------------------------------------------
// magia_tile_ctrl_mbox
//
// Control/status mailbox between the tile core (OBI subordinate side) and the
// simulation host. It holds the boot address and fetch enable used at core
// start-up, latches end-of-computation together with an exit code, and
// buffers console bytes in a small FIFO that the host-side VIP drains.
//
// Register map (offset = addr_i[4:2] * 4):
//   0x00 BOOT_ADDR  RW   byte enables honoured; host write has precedence
//   0x04 FETCH_EN   RW   bit0 only, other bits read 0; host set has precedence
//   0x08 EXIT       RW   first write sets EOC and captures the exit code,
//                        later writes are accepted and ignored
//   0x0C STATUS     RO   [0]=eoc [1]=fifo full [2]=fifo empty [15:8]=count
//   0x10 STDOUT     WO   be_i[0]=1 pushes wdata_i[7:0]; a read errors
//   0x14..0x1C      unmapped, any access errors
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i/gnt_o             OBI request / grant (grant is combinational)
//   addr_i, we_i, be_i,
//   wdata_i                 OBI request payload
//   rvalid_o, rdata_o,
//   err_o                   OBI response, exactly one cycle after the accept
//   host_boot_we_i,
//   host_boot_addr_i        host-side boot address load
//   host_fetch_en_i         host-side fetch-enable set pulse
//   boot_addr_o,
//   fetch_en_o              core start-up controls
//   eoc_o, exit_code_o      end-of-computation (sticky) and exit code
//   stdout_valid_o,
//   stdout_data_o,
//   stdout_ready_i          console byte stream towards the host
// -----------------------------------------------------------------------------
module magia_tile_ctrl_mbox #(
  parameter int unsigned DATA_W            = 32,
  parameter logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  // OBI subordinate port
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,

  // Host-side controls
  input  logic              host_boot_we_i,
  input  logic [31:0]       host_boot_addr_i,
  input  logic              host_fetch_en_i,

  // Core start-up and completion status
  output logic [31:0]       boot_addr_o,
  output logic              fetch_en_o,
  output logic              eoc_o,
  output logic [DATA_W-1:0] exit_code_o,

  // Console byte stream
  output logic              stdout_valid_o,
  output logic [7:0]        stdout_data_o,
  input  logic              stdout_ready_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    REG_BOOT   = 3'd0,
    REG_FETCH  = 3'd1,
    REG_EXIT   = 3'd2,
    REG_STATUS = 3'd3,
    REG_STDOUT = 3'd4,
    REG_RSVD5  = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_e;

  // Merge a write into an existing word under byte enables.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]       boot_q, boot_d;
  logic              fetch_q, fetch_d;
  logic              eoc_q, eoc_d;
  logic [DATA_W-1:0] exit_q, exit_d;

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  // Only addr_i[4:2] selects a register; the rest of the address is ignored.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Decode and handshake
  // ---------------------------------------------------------------------------
  reg_e reg_sel;
  assign reg_sel = reg_e'(addr_i[4:2]);

  logic fifo_full, fifo_empty;
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // A console write is held off while the FIFO is full. Fullness comes from
  // the registered count only, so a pop in the same cycle does not release
  // the stall until the next cycle.
  logic stdout_stall;
  assign stdout_stall = req_i & we_i & (reg_sel == REG_STDOUT) & fifo_full;

  assign gnt_o = req_i & ~stdout_stall;

  logic accept, wr_accept;
  assign accept    = req_i & gnt_o;
  assign wr_accept = accept & we_i;

  logic push, pop;
  assign push = wr_accept & (reg_sel == REG_STDOUT) & be_i[0];
  assign pop  = stdout_ready_i & ~fifo_empty;

  logic [31:0] status_word;
  assign status_word = {16'h0000, 8'(count_q), 5'b0_0000,
                        fifo_empty, fifo_full, eoc_q};

  // ---------------------------------------------------------------------------
  // Response for the transfer accepted this cycle
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    unique case (reg_sel)
      REG_BOOT:   if (!we_i) rdata_d = boot_q;
      REG_FETCH:  if (!we_i) rdata_d = {{(DATA_W-1){1'b0}}, fetch_q};
      REG_EXIT:   if (!we_i) rdata_d = exit_q;
      REG_STATUS: begin
        if (we_i) err_d   = 1'b1;
        else      rdata_d = status_word;
      end
      REG_STDOUT: if (!we_i) err_d = 1'b1;
      default:    err_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control register next state
  // ---------------------------------------------------------------------------
  always_comb begin
    boot_d  = boot_q;
    fetch_d = fetch_q;
    eoc_d   = eoc_q;
    exit_d  = exit_q;

    // Host load of the boot address overrides a concurrent bus write.
    if (host_boot_we_i) begin
      boot_d = host_boot_addr_i;
    end else if (wr_accept && reg_sel == REG_BOOT) begin
      boot_d = apply_be(boot_q, wdata_i, be_i);
    end

    // Host set of fetch enable overrides a concurrent bus write of 0.
    if (host_fetch_en_i) begin
      fetch_d = 1'b1;
    end else if (wr_accept && reg_sel == REG_FETCH && be_i[0]) begin
      fetch_d = wdata_i[0];
    end

    // EOC is sticky: only the first EXIT write captures a code.
    if (wr_accept && reg_sel == REG_EXIT && !eoc_q) begin
      eoc_d  = 1'b1;
      exit_d = apply_be(exit_q, wdata_i, be_i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      boot_q   <= BOOT_ADDR_DEFAULT;
      fetch_q  <= 1'b0;
      eoc_q    <= 1'b0;
      exit_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      boot_q   <= boot_d;
      fetch_q  <= fetch_d;
      eoc_q    <= eoc_d;
      exit_q   <= exit_d;
      rvalid_q <= accept;
      rdata_q  <= accept ? rdata_d : '0;
      err_q    <= accept & err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Console FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are PTR_W wide and FIFO_DEPTH is a power of two, so they wrap
  // modulo the depth on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it was written, because validity is tracked by the reset pointers/count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= wdata_i[7:0];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign err_o          = err_q;

  assign boot_addr_o    = boot_q;
  assign fetch_en_o     = fetch_q;
  assign eoc_o          = eoc_q;
  assign exit_code_o    = exit_q;

  assign stdout_valid_o = ~fifo_empty;
  assign stdout_data_o  = fifo_mem_q[rd_ptr_q];

endmodule
